// File: rtl/fifo_accumulator_pkg.sv
// Shared width helpers and sequencer state encoding for the channel FIFO accumulator.
package fifo_accumulator_pkg;

    localparam int unsigned DEF_CHANNEL_WIDTH      = 32;
    localparam int unsigned DEF_CHANNEL_DEPTH      = 128;
    localparam int unsigned DEF_CHANNELS_CNT       = 5;
    localparam int unsigned DEF_CHANNEL_ACC_ROUNDS = 5;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fill counters must be able to represent DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned channel_idx_width(input int unsigned channels);
        return idx_width(channels);
    endfunction

    function automatic int unsigned round_idx_width(input int unsigned rounds);
        return idx_width(rounds);
    endfunction

    typedef enum logic [1:0] {
        SEQ_WAIT_TRIG = 2'd0,
        SEQ_RECORD    = 2'd1,
        SEQ_READOUT   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with registered fill count and flags.
module fifo_sync_fwft
    import fifo_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128,
    localparam int unsigned CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_empty_next,
    output logic             o_full,
    output logic             o_full_next,
    output logic [CW-1:0]    o_fill_count
);

    localparam int unsigned AW = idx_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_empty_next;
    logic             r_full;
    logic             r_full_next;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_nx;

    // A push into a full FIFO is legal when the head is popped in the same cycle.
    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    always_comb begin
        w_count_nx = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nx = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_nx = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_empty_next <= 1'b0;
            r_full       <= 1'b0;
            r_full_next  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count      <= w_count_nx;
            r_empty      <= (w_count_nx == '0);
            r_empty_next <= (w_count_nx == CW'(1));
            r_full       <= (w_count_nx == CW'(DEPTH));
            r_full_next  <= (w_count_nx == CW'(DEPTH - 1));
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_empty      = r_empty;
    assign o_empty_next = r_empty_next;
    assign o_full       = r_full;
    assign o_full_next  = r_full_next;
    assign o_fill_count = r_count;

endmodule

// File: rtl/channel_fifo_accumulator.sv
// Round-robin record sequencer summing records in place inside per-channel FWFT FIFOs.
module channel_fifo_accumulator
    import fifo_accumulator_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH      = DEF_CHANNEL_WIDTH,
    parameter int unsigned CHANNEL_DEPTH      = DEF_CHANNEL_DEPTH,
    parameter int unsigned CHANNELS_CNT       = DEF_CHANNELS_CNT,
    parameter int unsigned CHANNEL_ACC_ROUNDS = DEF_CHANNEL_ACC_ROUNDS,
    localparam int unsigned COUNT_W           = count_width(CHANNEL_DEPTH)
) (
    input  logic                                        clk,
    input  logic                                        i_rst,
    input  logic                                        i_acc_trigger,
    input  logic                                        i_data_valid,
    input  logic [CHANNEL_WIDTH-1:0]                    i_data,
    output logic                                        o_acc_valid,
    input  logic [CHANNELS_CNT-1:0]                     i_rd_en_channels,
    output logic [CHANNELS_CNT-1:0]                     o_rd_valid_channels,
    output logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0]  o_rd_data_channels,
    output logic [CHANNELS_CNT-1:0]                     o_ready_channels,
    output logic [CHANNELS_CNT-1:0]                     o_empty_channels,
    output logic [CHANNELS_CNT-1:0]                     o_empty_next_channels,
    output logic [CHANNELS_CNT-1:0]                     o_full_channels,
    output logic [CHANNELS_CNT-1:0]                     o_full_next_channels,
    output logic [CHANNELS_CNT-1:0][COUNT_W-1:0]        o_fill_count_channels
);

    localparam int unsigned CH_W   = channel_idx_width(CHANNELS_CNT);
    localparam int unsigned RND_W  = round_idx_width(CHANNEL_ACC_ROUNDS);
    localparam int unsigned WORD_W = idx_width(CHANNEL_DEPTH);

    seq_state_t          r_state;
    logic [CH_W-1:0]     r_ch_idx;
    logic [RND_W-1:0]    r_round;
    logic [WORD_W-1:0]   r_word_idx;
    logic                r_acc_valid;

    logic                w_word;
    logic                w_last_word;
    logic                w_last_ch;
    logic                w_last_round;
    logic                w_first_round;
    logic                w_all_empty;

    logic [CHANNELS_CNT-1:0] w_empty;

    assign w_word        = (r_state == SEQ_RECORD) && i_data_valid;
    assign w_last_word   = (r_word_idx == WORD_W'(CHANNEL_DEPTH - 1));
    assign w_last_ch     = (r_ch_idx == CH_W'(CHANNELS_CNT - 1));
    assign w_last_round  = (r_round == RND_W'(CHANNEL_ACC_ROUNDS - 1));
    assign w_first_round = (r_round == '0);
    assign w_all_empty   = &w_empty;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= SEQ_WAIT_TRIG;
            r_ch_idx    <= '0;
            r_round     <= '0;
            r_word_idx  <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            case (r_state)
                SEQ_WAIT_TRIG: begin
                    if (i_acc_trigger) begin
                        r_state    <= SEQ_RECORD;
                        r_word_idx <= '0;
                    end
                end
                SEQ_RECORD: begin
                    if (i_data_valid) begin
                        if (w_last_word) begin
                            r_word_idx <= '0;
                            r_ch_idx   <= w_last_ch ? '0 : r_ch_idx + 1'b1;
                            if (w_last_ch) begin
                                r_round <= w_last_round ? '0 : r_round + 1'b1;
                            end
                            if (w_last_ch && w_last_round) begin
                                r_state     <= SEQ_READOUT;
                                r_acc_valid <= 1'b1;
                            end else begin
                                r_state <= SEQ_WAIT_TRIG;
                            end
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                SEQ_READOUT: begin
                    // Readout ends only when every channel has been fully drained.
                    if (w_all_empty) begin
                        r_state     <= SEQ_WAIT_TRIG;
                        r_acc_valid <= 1'b0;
                        r_ch_idx    <= '0;
                        r_round     <= '0;
                        r_word_idx  <= '0;
                    end
                end
                default: begin
                    r_state <= SEQ_WAIT_TRIG;
                end
            endcase
        end
    end

    assign o_acc_valid      = r_acc_valid;
    assign o_empty_channels = w_empty;
    assign o_ready_channels = r_acc_valid ? ~w_empty : '0;

    for (genvar c = 0; c < int'(CHANNELS_CNT); c++) begin : g_ch
        logic                     w_sel;
        logic                     w_acc_pop;
        logic                     w_rd_pop;
        logic                     w_pop;
        logic [CHANNEL_WIDTH-1:0] w_head;
        logic [CHANNEL_WIDTH-1:0] w_push_data;
        logic                     r_rd_valid;
        logic [CHANNEL_WIDTH-1:0] r_rd_data;

        // Later rounds recirculate: the head is popped and pushed back with the new sample added.
        assign w_sel       = w_word && (r_ch_idx == CH_W'(c));
        assign w_acc_pop   = w_sel && !w_first_round;
        assign w_rd_pop    = r_acc_valid && i_rd_en_channels[c] && !w_empty[c];
        assign w_pop       = w_acc_pop || w_rd_pop;
        assign w_push_data = w_first_round ? i_data : w_head + i_data;

        fifo_sync_fwft #(
            .WIDTH (CHANNEL_WIDTH),
            .DEPTH (CHANNEL_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .i_rst        (i_rst),
            .i_push       (w_sel),
            .i_data       (w_push_data),
            .i_pop        (w_pop),
            .o_head       (w_head),
            .o_empty      (w_empty[c]),
            .o_empty_next (o_empty_next_channels[c]),
            .o_full       (o_full_channels[c]),
            .o_full_next  (o_full_next_channels[c]),
            .o_fill_count (o_fill_count_channels[c])
        );

        always_ff @(posedge clk) begin
            if (i_rst) begin
                r_rd_valid <= 1'b0;
                r_rd_data  <= '0;
            end else begin
                r_rd_valid <= w_rd_pop;
                if (w_rd_pop) begin
                    r_rd_data <= w_head;
                end
            end
        end

        assign o_rd_valid_channels[c] = r_rd_valid;
        assign o_rd_data_channels[c]  = r_rd_data;
    end

endmodule

// File: tb/tb_channel_fifo_accumulator.sv
// Scoreboard bench: a reference accumulation model queues expected read data per channel.
module tb_channel_fifo_accumulator;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 128;
    localparam int unsigned N  = 5;
    localparam int unsigned R  = 5;
    localparam int unsigned CW = $clog2(D) + 1;
    localparam int TOTAL_REC   = N * R;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  trig = 1'b0;
    logic                  valid = 1'b0;
    logic [W-1:0]          data = '0;
    logic                  acc_valid;
    logic [N-1:0]          rd_en = '0;
    logic [N-1:0]          rd_valid;
    logic [N-1:0][W-1:0]   rd_data;
    logic [N-1:0]          ready;
    logic [N-1:0]          empty;
    logic [N-1:0]          empty_next;
    logic [N-1:0]          full;
    logic [N-1:0]          full_next;
    logic [N-1:0][CW-1:0]  fill;

    channel_fifo_accumulator #(
        .CHANNEL_WIDTH      (W),
        .CHANNEL_DEPTH      (D),
        .CHANNELS_CNT       (N),
        .CHANNEL_ACC_ROUNDS (R)
    ) dut (
        .clk                   (clk),
        .i_rst                 (rst),
        .i_acc_trigger         (trig),
        .i_data_valid          (valid),
        .i_data                (data),
        .o_acc_valid           (acc_valid),
        .i_rd_en_channels      (rd_en),
        .o_rd_valid_channels   (rd_valid),
        .o_rd_data_channels    (rd_data),
        .o_ready_channels      (ready),
        .o_empty_channels      (empty),
        .o_empty_next_channels (empty_next),
        .o_full_channels       (full),
        .o_full_next_channels  (full_next),
        .o_fill_count_channels (fill)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_acc [N][D];
    logic [W-1:0] exp_q [N][$];
    int           model_fill [N];
    int           model_rd [N];
    int           rec_no = 0;
    bit           model_done = 1'b0;
    logic [N-1:0] pending = '0;
    bit           mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < D; k++) model_acc[c][k] = '0;
            model_fill[c] = 0;
            model_rd[c]   = 0;
        end
        rec_no     = 0;
        model_done = 1'b0;
    endtask

    // Monitor: every cycle, rd_valid must match the honoured requests of the previous cycle.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk("rd_valid", 64'(rd_valid), 64'(pending));
            for (int c = 0; c < N; c++) begin
                if (rd_valid[c]) begin
                    if (exp_q[c].size() == 0) chk("rd_spurious", 64'd1, 64'd0);
                    else chk("rd_data", 64'(rd_data[c]), 64'(exp_q[c].pop_front()));
                end
            end
        end
    end

    task automatic send_record(input int mode, input int nwords, input bit mid_trig);
        int ch;
        ch = rec_no % N;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        for (int k = 0; k < nwords; k++) begin
            valid = 1'b1;
            data  = (mode == 1) ? 32'hFFFF_FFFF : W'(k + 1);
            trig  = mid_trig && (k == 40 || k == 90);
            if (k < D) model_acc[ch][k] = model_acc[ch][k] + data;
            if (k == D - 1 && rec_no == TOTAL_REC - 1) chk("acc_valid_early", 64'(acc_valid), 64'd0);
            @(negedge clk);
        end
        valid = 1'b0;
        trig  = 1'b0;
        if (nwords >= D) begin
            rec_no++;
            if (rec_no == TOTAL_REC) begin
                model_done = 1'b1;
                for (int c = 0; c < N; c++) model_fill[c] = D;
            end
        end
    endtask

    task automatic read_cycle(input logic [N-1:0] mask);
        rd_en   = mask;
        pending = '0;
        for (int c = 0; c < N; c++) begin
            if (mask[c] && model_done && model_fill[c] > 0) begin
                pending[c] = 1'b1;
                exp_q[c].push_back(model_acc[c][model_rd[c]]);
                model_rd[c]++;
                model_fill[c]--;
            end
        end
        @(negedge clk);
        rd_en   = '0;
        pending = '0;
    endtask

    task automatic chk_done_state();
        chk("acc_valid_done", 64'(acc_valid), 64'd1);
        for (int c = 0; c < N; c++) begin
            chk("fill_done", 64'(fill[c]), 64'(D));
            chk("full_done", 64'(full[c]), 64'd1);
            chk("full_next_done", 64'(full_next[c]), 64'd0);
            chk("ready_done", 64'(ready[c]), 64'd1);
        end
    endtask

    task automatic chk_idle_after_drain();
        repeat (3) @(negedge clk);
        chk("acc_valid_drained", 64'(acc_valid), 64'd0);
        chk("empty_drained", 64'(empty), 64'({N{1'b1}}));
        chk("ready_drained", 64'(ready), 64'd0);
        for (int c = 0; c < N; c++) chk("fill_drained", 64'(fill[c]), 64'd0);
        for (int c = 0; c < N; c++) chk("queue_drained", 64'(exp_q[c].size()), 64'd0);
        model_clear();
    endtask

    task automatic drain_sequential();
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < D; k++) begin
                read_cycle(N'(1) << c);
                if (k == 0) chk("full_next_127", 64'(full_next[c]), 64'd1);
                if (k == D - 2) begin
                    chk("fill_one", 64'(fill[c]), 64'd1);
                    chk("empty_next_one", 64'(empty_next[c]), 64'd1);
                end
            end
        end
        chk_idle_after_drain();
    endtask

    task automatic chk_reset_vals();
        chk("rst_acc_valid", 64'(acc_valid), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_empty", 64'(empty), 64'({N{1'b1}}));
        chk("rst_empty_next", 64'(empty_next), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_full_next", 64'(full_next), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
    endtask

    task automatic run_accum(input int mode, input int nwords, input bit mid_trig);
        for (int r = 0; r < TOTAL_REC; r++) begin
            send_record(mode, nwords, mid_trig);
            if (r == 2) begin
                read_cycle('1);
                for (int c = 0; c < N; c++)
                    chk("fill_early_rd", 64'(fill[c]), (c < 3) ? 64'(D) : 64'd0);
            end
        end
        chk_done_state();
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        read_cycle('1);
        for (int c = 0; c < N; c++) chk("fill_empty_rd", 64'(fill[c]), 64'd0);

        run_accum(0, D, 1'b0);
        drain_sequential();

        run_accum(1, D, 1'b0);
        for (int k = 0; k < D; k++) read_cycle('1);
        chk_idle_after_drain();

        run_accum(0, 200, 1'b1);
        drain_sequential();

        for (int r = 0; r < 12; r++) send_record(0, D, 1'b0);
        send_record(0, 60, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        model_clear();
        @(negedge clk);

        run_accum(0, D, 1'b0);
        drain_sequential();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
